rr_arbiter_4: RTL
=================

# rr_arbiter_4

Four-requester arbiter that shares one downstream resource, such as a bus or a datapath port, between requesters `req[3:0]`. It uses the same priority-encoding convention as the combinational priority encoders: the highest index wins. It adds two things on top of that convention:
- a selectable rotating (round-robin) priority, so no requester starves;
- registered, held grants, so the winner keeps the resource until it releases it or hits a hold limit.

The block sits between the requesters and the shared resource.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held. 0 means unlimited. Legal range 0..255.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  4: request lines; `req[i]` is held high by requester i while it wants the resource.
- `rr_en`  in  1: 1 = round-robin priority; 0 = fixed priority (3 > 2 > 1 > 0).
- `gnt`  out  4: one-hot grant vector, registered. All zeros when idle.
- `gnt_id`  out  2: binary index of the current owner. Valid only while `busy`=1.
- `busy`  out  1: 1 while any grant is active (equals the OR of `gnt`).

## Operation
- Two states:
  - IDLE: no owner.
  - GRANT: one owner, index held in `gnt_id`.
- Internal state:
  - `ptr[1:0]`: round-robin pointer.
  - `hold_cnt`: width is ceil(log2(MAX_HOLD+1)), minimum 1.
- Priority order:
  - `rr_en`=0: order is 3,2,1,0.
  - `rr_en`=1: order is `ptr`, `ptr`-1, `ptr`-2, `ptr`-3, all mod 4.
  - `rr_en` is sampled only at arbitration edges. Changing it mid-grant does not disturb the current owner.
- Arbitration edge: any edge where the state is IDLE, or the state is GRANT and a release condition is true. At that edge:
  - If `req`≠0: grant the highest-priority requesting index, set `hold_cnt`=1, set `ptr`=(winner−1) mod 4. `ptr` is updated in both modes.
  - If `req`=0: go to IDLE with `gnt`=0 and `busy`=0. `ptr` is unchanged.
- Release conditions, evaluated in GRANT:
  - (a) `req[gnt_id]`=0; or
  - (b) `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD`, and the owner is still requesting.
- Forced release (b):
  - Because `ptr` already points past the owner, the owner has lowest priority in round-robin mode.
  - If no other requester is active, the owner is re-granted and `hold_cnt` restarts at 1.
  - In fixed mode, the owner is re-granted whenever it still has the highest active priority.
- No release: `hold_cnt` increments when `MAX_HOLD`≠0, and saturates at `MAX_HOLD`. When `MAX_HOLD`=0 the counter is held at 0.
- Requests arriving from non-owners during GRANT are not acted on until the next arbitration edge.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - Outputs: `gnt`=4'b0000, `gnt_id`=2'b00, `busy`=0.
  - Internal: `ptr`=2'b11, `hold_cnt`=0, state IDLE.
  - `rst` overrides everything, including mid-grant. The grant drops on the edge that samples `rst`=1.
  - First arbitration is at the first edge with `rst`=0.
- Grant latency: `req` is sampled at edge N and `gnt` is visible after edge N, i.e. one cycle of latency.
- Owner release: the owner drops `req` before edge M. After edge M either `gnt` is 0 or it has switched directly to the new winner. There is no dead cycle when other requests are pending.
- Hold limit: a continuously requesting owner that faces contention holds `gnt` for exactly `MAX_HOLD` cycles.
- `gnt`, `gnt_id` and `busy` all change on the same edge. `gnt` is never multi-hot.

## Test plan
- Reset and idle:
  - Assert `rst` with `req`=4'b1111 → after the edge, `gnt`=0 and `busy`=0.
  - Release `rst` → the next edge gives `gnt`=4'b1000, `gnt_id`=3.
- Fixed priority:
  - Set `rr_en`=0, `MAX_HOLD`=0 and sweep `req` through 0..15, dropping `req` to 0 between values.
  - Required: `gnt_id` matches the 4-to-2 priority encoding of each value (e.g. 4'b0110 → 2, 4'b0001 → 0). For `req`=0, `busy`=0.
- Round-robin rotation:
  - Set `rr_en`=1, `MAX_HOLD`=0, `req`=4'b1111. Each owner drops its `req` for one cycle after 2 cycles of grant.
  - Required grant sequence: 3, 2, 1, 0, 3.
- Hold limit:
  - Set `MAX_HOLD`=4, `rr_en`=1, `req`=4'b1001 held constant.
  - Required: `gnt`=4'b1000 for exactly 4 cycles, then 4'b0001 for 4 cycles, then 4'b1000 again.
- Sole requester re-grant:
  - Set `MAX_HOLD`=3 and `req`=4'b0100 constant.
  - Required: `gnt` stays 4'b0100 continuously with no gap, and `hold_cnt` cycles 1,2,3,1.
- Reset mid-grant and mode switch:
  - Assert `rst` during a grant → `gnt`=0 next cycle and `ptr`=3.
  - Toggle `rr_en` mid-grant → the owner is unchanged until it releases.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter with fixed or round-robin priority and registered, held grants.
// An owner keeps the resource until it drops its request or reaches MAX_HOLD cycles.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LIM  = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] CNT_START = (MAX_HOLD != 0) ? HCW'(1) : '0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nx;
  logic [1:0]     ptr, ptr_nx;
  logic [1:0]     gnt_id_nx;
  logic [3:0]     gnt_nx;
  logic           busy_nx;
  logic [HCW-1:0] hold_cnt, hold_cnt_nx;
  logic           win_vld;
  logic [1:0]     win;
  logic           hold_hit;
  logic           rel;
  logic           arb;

  // k-th candidate in the priority order for the current mode.
  function automatic logic [1:0] prio_idx(input logic [1:0] p, input logic rr, input int k);
    logic [1:0] kk;
    kk = 2'(k);
    return rr ? (p - kk) : (2'd3 - kk);
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!win_vld && req[prio_idx(ptr, rr_en, k)]) begin
        win_vld = 1'b1;
        win     = prio_idx(ptr, rr_en, k);
      end
    end
  end

  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
  assign rel      = (state == GRANT) && (!req[gnt_id] || hold_hit);
  assign arb      = (state == IDLE) || rel;

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    gnt_id_nx   = gnt_id;
    gnt_nx      = gnt;
    busy_nx     = busy;
    hold_cnt_nx = hold_cnt;
    if (arb) begin
      if (win_vld) begin
        state_nx    = GRANT;
        gnt_id_nx   = win;
        gnt_nx      = 4'b0001 << win;
        busy_nx     = 1'b1;
        hold_cnt_nx = CNT_START;
        // Pointing just below the winner makes it the lowest priority next time.
        ptr_nx      = win - 2'd1;
      end else begin
        state_nx    = IDLE;
        gnt_nx      = 4'b0000;
        busy_nx     = 1'b0;
        hold_cnt_nx = '0;
      end
    end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIM)) begin
      hold_cnt_nx = hold_cnt + HCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'b11;
      gnt_id   <= 2'b00;
      gnt      <= 4'b0000;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      gnt_id   <= gnt_id_nx;
      gnt      <= gnt_nx;
      busy     <= busy_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

endmodule
